// File: rtl/mole_game_pkg.sv
// Shared types and constants for the mole game datapath: round states,
// default timing/score limits, display-facing widths and the score arithmetic.
package mole_game_pkg;

  localparam int CLK_HZ_DEF    = 1_000_000;
  localparam int GAME_SEC_DEF  = 60;
  localparam int SCORE_MAX_DEF = 999;

  localparam int TIMER_W      = 7;
  localparam int SCORE_W      = 10;
  localparam int SCORE_CALC_W = SCORE_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } game_state_e;

  // Hit is applied before miss; the floor and the ceiling act only on the combined result.
  function automatic logic [SCORE_W-1:0] score_step(
    input logic [SCORE_W-1:0]      cur,
    input logic                    add_en,
    input logic [SCORE_CALC_W-1:0] add_pts,
    input logic                    sub_en,
    input logic [SCORE_CALC_W-1:0] sub_pts,
    input logic [SCORE_CALC_W-1:0] max_pts
  );
    logic [SCORE_CALC_W-1:0] acc;
    acc = {1'b0, cur};
    if (add_en) begin
      acc = acc + add_pts;
    end else begin
      acc = acc;
    end
    if (sub_en) begin
      acc = (acc >= sub_pts) ? (acc - sub_pts) : {SCORE_CALC_W{1'b0}};
    end else begin
      acc = acc;
    end
    if (acc > max_pts) begin
      acc = max_pts;
    end else begin
      acc = acc;
    end
    return acc[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/game_timer_score_if.sv
// Control and status bundle between the game logic and the round controller;
// outputs feed the 7-segment driver directly.
interface game_timer_score_if;
  import mole_game_pkg::*;

  logic               start;
  logic               hit;
  logic               miss;
  logic [TIMER_W-1:0] timer;
  logic               is_timer_running;
  logic [SCORE_W-1:0] score;
  logic               game_over;
  logic               done_pulse;

  modport master (
    output start, hit, miss,
    input  timer, is_timer_running, score, game_over, done_pulse
  );

  modport slave (
    input  start, hit, miss,
    output timer, is_timer_running, score, game_over, done_pulse
  );
endinterface

// File: rtl/game_timer_score_sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and flags the wrap cycle.
module sec_tick_gen
  import mole_game_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF
) (
  input  logic clk_1mhz,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic sec_tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_r;

  // Prescaler counter; a clear always restarts a full second.
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= (cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sec_tick = en & (cnt_r == CNT_LAST);

endmodule

// File: rtl/game_timer_score.sv
// Round controller: IDLE/RUN/DONE countdown plus saturating score.
// Optional build macro MISS_PENALTY_EN makes miss pulses subtract MISS_POINTS.
module game_timer_score
  import mole_game_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int GAME_SEC    = GAME_SEC_DEF,
  parameter int SCORE_MAX   = SCORE_MAX_DEF,
  parameter int HIT_POINTS  = 1,
  parameter int MISS_POINTS = 1
) (
  input  logic               clk_1mhz,
  input  logic               rst_n,
  game_timer_score_if.slave  bus
);

  localparam logic [TIMER_W-1:0]      GAME_SEC_T = TIMER_W'(GAME_SEC);
  localparam logic [SCORE_CALC_W-1:0] HIT_PTS    = SCORE_CALC_W'(HIT_POINTS);
  localparam logic [SCORE_CALC_W-1:0] MISS_PTS   = SCORE_CALC_W'(MISS_POINTS);
  localparam logic [SCORE_CALC_W-1:0] SCORE_CAP  = SCORE_CALC_W'(SCORE_MAX);
`ifdef MISS_PENALTY_EN
  localparam logic MISS_EN = 1'b1;
`else
  localparam logic MISS_EN = 1'b0;
`endif

  game_state_e        state_r;
  game_state_e        state_nxt_s;
  logic [TIMER_W-1:0] timer_r;
  logic [TIMER_W-1:0] timer_nxt_s;
  logic [SCORE_W-1:0] score_r;
  logic [SCORE_W-1:0] score_nxt_s;
  logic               running_r;
  logic               over_r;
  logic               done_r;
  logic               done_nxt_s;
  logic               clr_s;
  logic               tick_en_s;
  logic               sec_tick_s;

  assign tick_en_s = (state_r == ST_RUN);

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick_gen (
    .clk_1mhz (clk_1mhz),
    .rst_n    (rst_n),
    .clr      (clr_s),
    .en       (tick_en_s),
    .sec_tick (sec_tick_s)
  );

  // Next-state, countdown and score decisions.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    score_nxt_s = score_r;
    done_nxt_s  = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          timer_nxt_s = GAME_SEC_T;
          score_nxt_s = {SCORE_W{1'b0}};
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        // A start pulse here is deliberately ignored: rounds never restart mid-run.
        score_nxt_s = score_step(score_r, bus.hit, HIT_PTS,
                                 bus.miss & MISS_EN, MISS_PTS, SCORE_CAP);
        if (sec_tick_s) begin
          timer_nxt_s = timer_r - 7'd1;
          if (timer_r == 7'd1) begin
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          timer_nxt_s = timer_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        timer_nxt_s = GAME_SEC_T;
        score_nxt_s = {SCORE_W{1'b0}};
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      timer_r   <= GAME_SEC_T;
      score_r   <= {SCORE_W{1'b0}};
      running_r <= 1'b0;
      over_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      score_r   <= score_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      over_r    <= (state_nxt_s == ST_DONE);
      done_r    <= done_nxt_s;
    end
  end

  assign bus.timer            = timer_r;
  assign bus.score            = score_r;
  assign bus.is_timer_running = running_r;
  assign bus.game_over        = over_r;
  assign bus.done_pulse       = done_r;

endmodule

// File: tb/tb_game_timer_score.sv
// Bench for game_timer_score: random hit/miss/start traffic against a
// cycle-count based round model; honours MISS_PENALTY_EN.
module tb_game_timer_score;
  import mole_game_pkg::*;

  localparam int CLK_HZ      = 10;
  localparam int GAME_SEC    = 3;
  localparam int SCORE_MAX   = 5;
  localparam int HIT_POINTS  = 1;
  localparam int MISS_POINTS = 1;
  localparam int ROUND_CYC   = GAME_SEC * CLK_HZ;
`ifdef MISS_PENALTY_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic clk_1mhz = 1'b0;
  logic rst_n    = 1'b0;

  game_timer_score_if bus();

  game_timer_score #(
    .CLK_HZ      (CLK_HZ),
    .GAME_SEC    (GAME_SEC),
    .SCORE_MAX   (SCORE_MAX),
    .HIT_POINTS  (HIT_POINTS),
    .MISS_POINTS (MISS_POINTS)
  ) dut (
    .clk_1mhz (clk_1mhz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: round progress is just elapsed cycles since the start edge.
  bit m_run, m_over, m_done;
  int m_timer, m_score, m_elapsed;

  function automatic int apply_score(int cur, bit h, bit m);
    int v;
    v = cur;
    if (h) v = v + HIT_POINTS;
    if (m && MISS_EN) v = v - MISS_POINTS;
    if (v < 0) v = 0;
    if (v > SCORE_MAX) v = SCORE_MAX;
    return v;
  endfunction

  function automatic void model_reset();
    m_run = 1'b0; m_over = 1'b0; m_done = 1'b0;
    m_timer = GAME_SEC; m_score = 0; m_elapsed = 0;
  endfunction

  function automatic void model_edge(bit h, bit m, bit s);
    m_done = 1'b0;
    if (m_run) begin
      m_score   = apply_score(m_score, h, m);
      m_elapsed = m_elapsed + 1;
      m_timer   = GAME_SEC - (m_elapsed / CLK_HZ);
      if (m_timer == 0) begin
        m_run = 1'b0; m_over = 1'b1; m_done = 1'b1;
      end
    end else if (s) begin
      m_run = 1'b1; m_over = 1'b0; m_score = 0;
      m_timer = GAME_SEC; m_elapsed = 0;
    end
  endfunction

  function automatic logic [19:0] exp_pack();
    return {TIMER_W'(m_timer), SCORE_W'(m_score), m_run, m_over, m_done};
  endfunction

  function automatic logic [19:0] dut_pack();
    return {bus.timer, bus.score, bus.is_timer_running, bus.game_over, bus.done_pulse};
  endfunction

  task automatic tick(input bit h, input bit m, input bit s);
    bus.hit = h; bus.miss = m; bus.start = s;
    @(posedge clk_1mhz);
    model_edge(h, m, s);
    #1;
    bus.hit = 1'b0; bus.miss = 1'b0; bus.start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int guard;
    guard = 0;
    while (m_run && guard < budget) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #13;
    n_tests++;
    if (dut_pack() !== exp_pack()) begin
      n_fail++; $display("FAIL reset_values: got %h want %h", dut_pack(), exp_pack());
    end
    n_tests++;
    if (bus.timer !== 7'd3) begin
      n_fail++; $display("FAIL reset_timer: got %0d want 3", bus.timer);
    end
    @(negedge clk_1mhz);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      n_tests++;
      if (dut_pack() !== exp_pack()) begin
        n_fail++; $display("FAIL idle_hold c%0d: got %h want %h", i, dut_pack(), exp_pack());
      end
    end
  endtask

  task automatic test_full_round();
    int done_at, done_cnt;
    done_at = -1; done_cnt = 0;
    tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (bus.is_timer_running !== 1'b1 || bus.timer !== 7'd3) begin
      n_fail++; $display("FAIL start_run: got run=%0d timer=%0d want run=1 timer=3",
                         bus.is_timer_running, bus.timer);
    end
    for (int k = 1; k <= ROUND_CYC + 10; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (dut_pack() !== exp_pack()) begin
        n_fail++; $display("FAIL round c%0d: got %h want %h", k, dut_pack(), exp_pack());
      end
      if (bus.done_pulse === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    n_tests++;
    if (done_at !== 30 || done_cnt !== 1) begin
      n_fail++; $display("FAIL done_timing: got at=%0d count=%0d want at=30 count=1", done_at, done_cnt);
    end
    n_tests++;
    if (bus.game_over !== 1'b1 || bus.timer !== 7'd0) begin
      n_fail++; $display("FAIL game_over: got over=%0d timer=%0d want 1/0", bus.game_over, bus.timer);
    end
  endtask

  task automatic test_hits_saturation();
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (bus.score !== 10'd5 || dut_pack() !== exp_pack()) begin
      n_fail++; $display("FAIL saturate: got score=%0d want 5", bus.score);
    end
    run_to_done(ROUND_CYC + 5);
    tick(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.score !== 10'd5 || bus.game_over !== 1'b1) begin
      n_fail++; $display("FAIL hit_in_done: got score=%0d over=%0d want 5/1", bus.score, bus.game_over);
    end
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < ROUND_CYC && m_elapsed < ROUND_CYC - 1; g++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.score !== 10'd3 || bus.done_pulse !== 1'b1 || dut_pack() !== exp_pack()) begin
      n_fail++; $display("FAIL final_tick_hit: got score=%0d done=%0d want 3/1", bus.score, bus.done_pulse);
    end
  endtask

  task automatic test_restart();
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (bus.timer !== 7'd2 || bus.score !== 10'd4 || dut_pack() !== exp_pack()) begin
      n_fail++; $display("FAIL start_in_run: got timer=%0d score=%0d want 2/4", bus.timer, bus.score);
    end
    run_to_done(ROUND_CYC + 5);
    n_tests++;
    if (bus.score !== 10'd4 || bus.game_over !== 1'b1) begin
      n_fail++; $display("FAIL done_score: got score=%0d over=%0d want 4/1", bus.score, bus.game_over);
    end
    tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (bus.score !== 10'd0 || bus.timer !== 7'd3 || bus.is_timer_running !== 1'b1 || bus.game_over !== 1'b0) begin
      n_fail++; $display("FAIL restart_done: got score=%0d timer=%0d run=%0d want 0/3/1",
                         bus.score, bus.timer, bus.is_timer_running);
    end
    run_to_done(ROUND_CYC + 5);
  endtask

  task automatic test_miss();
    tick(1'b0, 1'b0, 1'b1);
`ifdef MISS_PENALTY_EN
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (bus.score !== 10'd0) begin
      n_fail++; $display("FAIL miss_floor: got score=%0d want 0", bus.score);
    end
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (bus.score !== 10'd1) begin
      n_fail++; $display("FAIL hit_and_miss: got score=%0d want 1", bus.score);
    end
`else
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (bus.score !== 10'd1) begin
      n_fail++; $display("FAIL miss_ignored: got score=%0d want 1", bus.score);
    end
    tick(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (bus.score !== 10'd2) begin
      n_fail++; $display("FAIL hit_and_miss: got score=%0d want 2", bus.score);
    end
`endif
    n_tests++;
    if (dut_pack() !== exp_pack()) begin
      n_fail++; $display("FAIL miss_model: got %h want %h", dut_pack(), exp_pack());
    end
    run_to_done(ROUND_CYC + 5);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      tick(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < ROUND_CYC + 8; c++) begin
        tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        n_tests++;
        if (dut_pack() !== exp_pack()) begin
          n_fail++; $display("FAIL random r%0d c%0d: got %h want %h", r, c, dut_pack(), exp_pack());
        end
      end
    end
  endtask

  task automatic test_reset_mid_round();
    int first_dec, guard;
    first_dec = -1; guard = 0;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    while (m_timer != 2 && guard < ROUND_CYC) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
    end
    tick(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.timer !== 7'd3 || bus.score !== 10'd0 || bus.is_timer_running !== 1'b0 || dut_pack() !== exp_pack()) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", dut_pack(), exp_pack());
    end
    @(negedge clk_1mhz);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= CLK_HZ + 5; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (first_dec < 0 && bus.timer === 7'd2) first_dec = k;
    end
    n_tests++;
    if (first_dec !== 10) begin
      n_fail++; $display("FAIL tick_after_reset: got %0d want 10", first_dec);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0;
    test_reset();
    test_full_round();
    test_hits_saturation();
    test_restart();
    test_miss();
    test_random();
    test_reset_mid_round();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
